// File: rtl/fib_pkg.sv
// Shared encodings and constants for the Fibonacci index search.
package fib_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned VAL_W = 16;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(15);
  localparam logic [VAL_W-1:0] FIB_MAX = VAL_W'(610);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage : fib_pkg

// File: rtl/fib_index.sv
// Inverse Fibonacci: walks fib(0..15) one term per cycle and reports the
// smallest index whose term equals the sampled value.
module fib_index (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [3:0]  n
);
  import fib_pkg::*;

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   target_q, target_d;
  logic [VAL_W-1:0]   a_q, a_d;
  logic [VAL_W-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               found_d;
  logic [IDX_W-1:0]   n_d;
  logic               busy_d;
  logic               done_d;

  // Next state, datapath and registered-output next values.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    found_d  = found;
    n_d      = n;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = value;
          a_d      = VAL_W'(0);
          b_d      = VAL_W'(1);
          idx_d    = IDX_W'(0);
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        if (a_q == target_q) begin
          found_d = 1'b1;
          n_d     = idx_q;
          state_d = DONE;
        end else if ((a_q > target_q) || (idx_q == IDX_MAX)) begin
          found_d = 1'b0;
          n_d     = IDX_W'(0);
          state_d = DONE;
        end else begin
          // fib(16)=987 is the largest b ever formed, so 16 bits never wrap.
          a_d   = b_q;
          b_d   = a_q + b_q;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SEARCH);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= VAL_W'(0);
      a_q      <= VAL_W'(0);
      b_q      <= VAL_W'(1);
      idx_q    <= IDX_W'(0);
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      n        <= IDX_W'(0);
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      found    <= found_d;
      n        <= n_d;
    end
  end

endmodule : fib_index

// File: tb/tb_fib_index.sv
// Directed bench for fib_index: round trip, misses, edges, ignored start,
// mid-search reset and back-to-back operation.
module tb_fib_index;
  import fib_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [3:0]  n;

  int total;
  int bad;

  fib_index dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .found (found),
    .n     (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present start with a value and let the start-sampling edge pass.
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
  endtask

  // Step through cycles (counted from the start-sampling edge) until done.
  task automatic wait_done(input int c0, output int cyc, output bit seen);
    cyc  = c0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      seen = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    value = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, found, n} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b n=%0d, want all 0",
               busy, done, found, n);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_trip();
    logic [15:0] fib_tab [16];
    int cyc;
    bit seen;
    int exp_n;
    fib_tab = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
                16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};
    for (int i = 0; i < 16; i++) begin
      exp_n = (i == 2) ? 1 : i;
      launch(fib_tab[i]);
      wait_done(0, cyc, seen);
      total++;
      if (!seen || cyc != exp_n + 2 || found !== 1'b1 || n !== 4'(exp_n)) begin
        bad++;
        $display("FAIL round_trip[%0d]: got seen=%b cycles=%0d found=%b n=%0d, want cycles=%0d found=1 n=%0d",
                 i, seen, cyc, found, n, exp_n + 2, exp_n);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL done_single_cycle[%0d]: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_non_fib();
    logic [15:0] vals [3];
    int exp_cyc [3];
    int cyc;
    bit seen;
    vals    = '{16'd4, 16'(FIB_MAX) + 16'd1, 16'hFFFF};
    exp_cyc = '{7, 17, 17};
    for (int i = 0; i < 3; i++) begin
      launch(vals[i]);
      wait_done(0, cyc, seen);
      total++;
      if (!seen || cyc != exp_cyc[i] || found !== 1'b0 || n !== 4'd0) begin
        bad++;
        $display("FAIL non_fib[%0d]: got seen=%b cycles=%0d found=%b n=%0d, want cycles=%0d found=0 n=0",
                 vals[i], seen, cyc, found, n, exp_cyc[i]);
      end
    end
  endtask

  task automatic test_edges();
    int cyc;
    bit seen;
    launch(16'd0);
    wait_done(0, cyc, seen);
    total++;
    if (!seen || cyc != 2 || found !== 1'b1 || n !== 4'd0) begin
      bad++;
      $display("FAIL edge_zero: got seen=%b cycles=%0d found=%b n=%0d, want cycles=2 found=1 n=0",
               seen, cyc, found, n);
    end
    launch(16'(FIB_MAX));
    wait_done(0, cyc, seen);
    total++;
    if (!seen || cyc != 17 || found !== 1'b1 || n !== IDX_MAX) begin
      bad++;
      $display("FAIL edge_610: got seen=%b cycles=%0d found=%b n=%0d, want cycles=17 found=1 n=15",
               seen, cyc, found, n);
    end
    // The old result must survive into the next search.
    launch(16'd4);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || found !== 1'b1 || n !== 4'd15) begin
      bad++;
      $display("FAIL result_hold: got busy=%b found=%b n=%0d, want busy=1 found=1 n=15",
               busy, found, n);
    end
    wait_done(1, cyc, seen);
    total++;
    if (!seen || cyc != 7 || found !== 1'b0 || n !== 4'd0) begin
      bad++;
      $display("FAIL result_replace: got seen=%b cycles=%0d found=%b n=%0d, want cycles=7 found=0 n=0",
               seen, cyc, found, n);
    end
  endtask

  task automatic test_busy_start();
    int dones;
    int first_cyc;
    logic       got_found;
    logic [3:0] got_n;
    dones     = 0;
    first_cyc = 0;
    got_found = 1'b0;
    got_n     = 4'd0;
    launch(16'd13);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) value = 16'd5;
      if (c == 4) value = 16'd8;
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_cyc = c;
          got_found = found;
          got_n     = n;
        end
      end
    end
    total++;
    if (dones != 1 || first_cyc != 9 || got_found !== 1'b1 || got_n !== 4'd7) begin
      bad++;
      $display("FAIL busy_start: got dones=%0d cycle=%0d found=%b n=%0d, want dones=1 cycle=9 found=1 n=7",
               dones, first_cyc, got_found, got_n);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    int dones;
    launch(16'(FIB_MAX));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, found, n} !== 7'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b found=%b n=%0d, want all 0",
               busy, done, found, n);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_abort: got %0d done/busy cycles after reset, want 0", dones);
    end
    launch(16'd21);
    wait_done(0, cyc, seen);
    total++;
    if (!seen || cyc != 10 || found !== 1'b1 || n !== 4'd8) begin
      bad++;
      $display("FAIL reset_recover: got seen=%b cycles=%0d found=%b n=%0d, want cycles=10 found=1 n=8",
               seen, cyc, found, n);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int errs;
    logic exp_busy;
    logic exp_done;
    errs = 0;
    @(negedge clk);
    start = 1'b1;
    value = 16'd3;
    // fib(4)=3: five SEARCH cycles, one DONE, one IDLE, repeating.
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 21) start = 1'b0;
      p        = (c - 1) % 7;
      exp_busy = (p < 5);
      exp_done = (p == 5);
      total++;
      if (busy !== exp_busy || done !== exp_done || (exp_done && (found !== 1'b1 || n !== 4'd4))) begin
        bad++;
        errs++;
        $display("FAIL back_to_back[c=%0d]: got busy=%b done=%b found=%b n=%0d, want busy=%b done=%b",
                 c, busy, done, found, n, exp_busy, exp_done);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_stop: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_round_trip();
    test_non_fib();
    test_edges();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fib_index

// File: doc/fib_index.md
FIB_INDEX -- requirements
Module: fib_index

Interface
REQ-001 Parameters: none; index width fixed at 4 bits, value width fixed at 16 bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: value  input  16  candidate Fibonacci number; sampled with start.
REQ-006 Port: busy  output  1  high while a search is in progress (SEARCH state).
REQ-007 Port: done  output  1  one-cycle pulse marking result valid.
REQ-008 Port: found  output  1  1 = value equals fib(n) for some n in 0..15.
REQ-009 Port: n  output  4  smallest index with fib(n) == value; 0 when found = 0.

Function
REQ-010 Block SHALL be the inverse of the combinational fibonacci(n -> fib_n) block: fib(0)=0, fib(1)=1, fib(k)=fib(k-1)+fib(k-2), valid range n = 0..15, fib(15)=610.
REQ-011 FSM SHALL have states IDLE, SEARCH, DONE.
REQ-012 IDLE: on start=1, latch value into target, set a=0, b=1, idx=0, go to SEARCH; start=0 stays in IDLE.
REQ-013 SEARCH, one comparison per cycle, with a=fib(idx): if a==target, found<=1, n<=idx, go to DONE.
REQ-014 SEARCH: else if a>target, or idx==15, found<=0, n<=0, go to DONE.
REQ-015 SEARCH: else a<=b, b<=a+b, idx<=idx+1, stay in SEARCH.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 busy SHALL be 1 exactly in SEARCH; done SHALL be 1 exactly in DONE.
REQ-018 Latency: search ending at index k asserts done k+2 cycles after the start-sampling edge; worst case is 17 cycles.
REQ-019 value=1 SHALL report n=1, the smallest matching index, not n=2.
REQ-020 value > 610 SHALL terminate at idx==15 with found=0.
REQ-021 b SHALL be 16 bits; fib(16)=987 fits, so no overflow can occur.
REQ-022 start while in SEARCH or DONE SHALL be ignored, not queued.
REQ-023 A change of value after start is sampled SHALL not affect the running search.
REQ-024 found and n SHALL hold their last result until the next DONE; they are not cleared on start.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, found=0, n=0, a=0, b=1, idx=0, target=0.
REQ-026 Reset during SEARCH SHALL abort the search without a done pulse.
REQ-027 After rst_n rises, the first start SHALL be accepted on the next rising clk edge.

Structure
REQ-028 Shared package fib_pkg SHALL hold the state encoding (IDLE, SEARCH, DONE) and constants IDX_MAX=15 and FIB_MAX=610.
REQ-029 Single module, no sub-module; the adder and comparator are inline.
REQ-030 Outputs SHALL be registered; no combinational path from value or start to any output.

Verification
REQ-031 Round trip: for n=0..15, feed fibonacci(n) to value and pulse start -> found=1, n returned as sent, except input 2 -> n=1; done at n+2 cycles (input 2 -> 3 cycles).
REQ-032 Non-Fibonacci inputs: value=4 -> found=0, n=0, done 7 cycles after start; value=611 and value=16'hFFFF -> found=0, done 17 cycles after start.
REQ-033 Edges: value=0 -> found=1, n=0, done 2 cycles after start; value=610 -> found=1, n=15, done 17 cycles after start.
REQ-034 Busy start: start pulsed during SEARCH with a different value -> ignored; result matches the first value; exactly one done pulse.
REQ-035 Reset mid-operation: rst_n low in the 5th SEARCH cycle -> all outputs 0 at once, no done; new search after release -> correct result.
REQ-036 Back-to-back: start asserted continuously -> a new search begins the cycle after each DONE; busy low only in DONE and IDLE cycles.
